// File: rtl/boot_sequencer.sv
// Core bring-up: clear the register file, stream a program into imem, release the core.
// Define BOOT_CHECKSUM_EN to require a trailing XOR checksum word before release.
module boot_sequencer #(
    parameter int XLEN           = 64,
    parameter int IMEM_DEPTH     = 64,
    parameter int IMEM_AW        = $clog2(IMEM_DEPTH),
    parameter int RELEASE_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               restart,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [31:0]        in_data,
    input  logic               in_last,
    output logic               rf_we,
    output logic [4:0]         rf_waddr,
    output logic [XLEN-1:0]    rf_wdata,
    output logic               imem_we,
    output logic [IMEM_AW-1:0] imem_waddr,
    output logic [31:0]        imem_wdata,
    output logic               core_rstn,
    output logic               done,
    output logic               overflow,
    output logic [IMEM_AW:0]   words_loaded,
    output logic               err
);

`ifdef BOOT_CHECKSUM_EN
    typedef enum logic [2:0] {
        S_CLEAR, S_LOAD, S_CHECK, S_RELEASE, S_RUN, S_ERR
    } state_t;
    localparam state_t S_AFTER_LOAD = S_CHECK;
    localparam logic   KEEP_READY   = 1'b1;
`else
    typedef enum logic [1:0] {
        S_CLEAR, S_LOAD, S_RELEASE, S_RUN
    } state_t;
    localparam state_t S_AFTER_LOAD = S_RELEASE;
    localparam logic   KEEP_READY   = 1'b0;
`endif

    localparam int RW = $clog2(RELEASE_CYCLES + 1);
    localparam logic [IMEM_AW:0] LP_LAST = (IMEM_AW + 1)'(IMEM_DEPTH - 1);
    localparam logic [RW-1:0] LP_REL_END = RW'(RELEASE_CYCLES - 1);

    state_t              r_state;
    logic [4:0]          r_clr_cnt;
    logic [RW-1:0]       r_rel_cnt;
    logic                r_in_ready;
    logic                r_rf_we;
    logic [4:0]          r_rf_waddr;
    logic [XLEN-1:0]     r_rf_wdata;
    logic                r_imem_we;
    logic [IMEM_AW-1:0]  r_imem_waddr;
    logic [31:0]         r_imem_wdata;
    logic                r_core_rstn;
    logic                r_done;
    logic                r_overflow;
    logic [IMEM_AW:0]    r_words_loaded;
`ifdef BOOT_CHECKSUM_EN
    logic                r_err;
    logic [31:0]         r_csum;
`endif

    logic w_xfer;
    assign w_xfer = in_valid & r_in_ready;

    always_ff @(posedge clk) begin
        if (rst || restart) begin
            r_state        <= S_CLEAR;
            r_clr_cnt      <= '0;
            r_rel_cnt      <= '0;
            r_in_ready     <= 1'b0;
            r_rf_we        <= 1'b0;
            r_rf_waddr     <= '0;
            r_rf_wdata     <= '0;
            r_imem_we      <= 1'b0;
            r_imem_waddr   <= '0;
            r_imem_wdata   <= '0;
            r_core_rstn    <= 1'b0;
            r_done         <= 1'b0;
            r_overflow     <= 1'b0;
            r_words_loaded <= '0;
`ifdef BOOT_CHECKSUM_EN
            r_err          <= 1'b0;
            r_csum         <= '0;
`endif
        end else begin
            r_rf_we   <= 1'b0;
            r_imem_we <= 1'b0;
            unique case (r_state)
                S_CLEAR: begin
                    r_rf_we    <= 1'b1;
                    r_rf_waddr <= r_clr_cnt;
                    r_clr_cnt  <= r_clr_cnt + 5'd1;
                    if (r_clr_cnt == 5'd31)
                        r_state <= S_LOAD;
                end
                S_LOAD: begin
                    r_in_ready <= 1'b1;
                    if (w_xfer) begin
                        r_imem_we      <= 1'b1;
                        r_imem_waddr   <= r_words_loaded[IMEM_AW-1:0];
                        r_imem_wdata   <= in_data;
                        r_words_loaded <= r_words_loaded + 1'b1;
`ifdef BOOT_CHECKSUM_EN
                        r_csum         <= r_csum ^ in_data;
`endif
                        // A last word landing in the final slot is not an overflow.
                        if (in_last || r_words_loaded == LP_LAST) begin
                            r_overflow <= !in_last;
                            r_in_ready <= KEEP_READY;
                            r_state    <= S_AFTER_LOAD;
                            r_rel_cnt  <= '0;
                        end
                    end
                end
`ifdef BOOT_CHECKSUM_EN
                S_CHECK: begin
                    if (w_xfer) begin
                        r_in_ready <= 1'b0;
                        if (in_data == r_csum) begin
                            r_state <= S_RELEASE;
                        end else begin
                            r_state <= S_ERR;
                            r_err   <= 1'b1;
                        end
                    end
                end
`endif
                S_RELEASE: begin
                    r_rel_cnt <= r_rel_cnt + 1'b1;
                    if (r_rel_cnt == LP_REL_END) begin
                        r_state     <= S_RUN;
                        r_core_rstn <= 1'b1;
                        r_done      <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready     = r_in_ready;
    assign rf_we        = r_rf_we;
    assign rf_waddr     = r_rf_waddr;
    assign rf_wdata     = r_rf_wdata;
    assign imem_we      = r_imem_we;
    assign imem_waddr   = r_imem_waddr;
    assign imem_wdata   = r_imem_wdata;
    assign core_rstn    = r_core_rstn;
    assign done         = r_done;
    assign overflow     = r_overflow;
    assign words_loaded = r_words_loaded;
`ifdef BOOT_CHECKSUM_EN
    assign err          = r_err;
`else
    assign err          = 1'b0;
`endif

endmodule

// File: tb/tb_boot_sequencer.sv
// Directed bench for boot_sequencer: default instance plus an IMEM_DEPTH=4 instance.
// Honors BOOT_CHECKSUM_EN when the design is built with it.
module tb_boot_sequencer;

    localparam int RC = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        restart;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_last;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [63:0] rf_wdata;
    logic        imem_we;
    logic [5:0]  imem_waddr;
    logic [31:0] imem_wdata;
    logic        core_rstn;
    logic        done;
    logic        overflow;
    logic [6:0]  words_loaded;
    logic        err;

    logic        b_restart;
    logic        b_valid;
    logic        b_ready;
    logic [31:0] b_data;
    logic        b_last;
    logic        b_rf_we;
    logic [4:0]  b_rf_waddr;
    logic [63:0] b_rf_wdata;
    logic        b_imem_we;
    logic [1:0]  b_imem_waddr;
    logic [31:0] b_imem_wdata;
    logic        b_core_rstn;
    logic        b_done;
    logic        b_overflow;
    logic [2:0]  b_words;
    logic        b_err;

    always #5 clk = ~clk;

    boot_sequencer #(
        .XLEN(64), .IMEM_DEPTH(64), .RELEASE_CYCLES(RC)
    ) u_dut (
        .clk(clk), .rst(rst), .restart(restart),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .imem_we(imem_we), .imem_waddr(imem_waddr),
        .imem_wdata(imem_wdata), .core_rstn(core_rstn),
        .done(done), .overflow(overflow),
        .words_loaded(words_loaded), .err(err)
    );

    boot_sequencer #(
        .XLEN(64), .IMEM_DEPTH(4), .RELEASE_CYCLES(RC)
    ) u_dut4 (
        .clk(clk), .rst(rst), .restart(b_restart),
        .in_valid(b_valid), .in_ready(b_ready),
        .in_data(b_data), .in_last(b_last),
        .rf_we(b_rf_we), .rf_waddr(b_rf_waddr), .rf_wdata(b_rf_wdata),
        .imem_we(b_imem_we), .imem_waddr(b_imem_waddr),
        .imem_wdata(b_imem_wdata), .core_rstn(b_core_rstn),
        .done(b_done), .overflow(b_overflow),
        .words_loaded(b_words), .err(b_err)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Write-port monitors
    int          cyc      = 0;
    int          rf_run   = 0;
    int          last_run = 0;
    int          rf_bad   = 0;
    int          b_wcnt   = 0;
    int          b_bad    = 0;
    logic [5:0]  wq_addr[$];
    logic [31:0] wq_data[$];
    int          wq_cyc[$];

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (rf_we === 1'b1) begin
            rf_run <= rf_run + 1;
            if (rf_waddr !== rf_run[4:0] || rf_wdata !== '0)
                rf_bad <= rf_bad + 1;
        end else begin
            if (rf_run != 0)
                last_run <= rf_run;
            rf_run <= 0;
        end
        if (imem_we === 1'b1) begin
            wq_addr.push_back(imem_waddr);
            wq_data.push_back(imem_wdata);
            wq_cyc.push_back(cyc);
        end
        if (b_imem_we === 1'b1) begin
            if (b_imem_waddr !== b_wcnt[1:0])
                b_bad <= b_bad + 1;
            b_wcnt <= b_wcnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [31:0] csum_tb;

    task automatic send(input logic [31:0] d, input logic l);
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        while (in_ready !== 1'b1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("send_ready", in_ready, 1);
        if (in_ready === 1'b1)
            csum_tb ^= d;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic end_prog;
`ifdef BOOT_CHECKSUM_EN
        send(csum_tb, 1'b0);
`endif
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (in_ready !== 1'b1 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk(tag, in_ready, 1);
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (done !== 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk(tag, done, 1);
    endtask

    task automatic do_restart;
        restart = 1'b1;
        @(posedge clk); #1;
        restart = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] prog[3];
        logic [31:0] bw[6];
        int base;
        int b_acc;
        int b_exp_acc;

        prog[0] = 32'h00106433;
        prog[1] = 32'h0020e4b3;
        prog[2] = 32'h00000063;

        rst = 1'b1; restart = 1'b0;
        in_valid = 1'b0; in_data = '0; in_last = 1'b0;
        b_restart = 1'b0; b_valid = 1'b0; b_data = '0; b_last = 1'b0;
        csum_tb = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rf_we", rf_we, 0);
        chk("rst_rf_waddr", rf_waddr, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_core_rstn", core_rstn, 0);
        chk("rst_done", done, 0);
        chk("rst_words", words_loaded, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_err", err, 0);
        rst = 1'b0;

        // Register-file clear
        repeat (32) @(posedge clk);
        #1;
        chk("clr_addr31", rf_waddr, 31);
        chk("clr_we31", rf_we, 1);
        chk("clr_ready_lo", in_ready, 0);
        @(posedge clk); #1;
        chk("clr_we_off", rf_we, 0);
        chk("ready_rise", in_ready, 1);

        // Back-to-back three-word program
        base = wq_addr.size();
        csum_tb = '0;
        for (int i = 0; i < 3; i++)
            send(prog[i], i == 2);
        end_prog();
        chk("exit_ready_lo", in_ready, 0);
        chk("exit_rstn_lo", core_rstn, 0);
        for (int k = 1; k < RC; k++) begin
            @(posedge clk); #1;
            chk("rel_rstn_lo", core_rstn, 0);
        end
        @(posedge clk); #1;
        chk("rel_rstn_hi", core_rstn, 1);
        chk("rel_done", done, 1);
        chk("clr_run", last_run, 32);
        chk("clr_bad", rf_bad, 0);
        chk("p3_words", words_loaded, 3);
        chk("p3_nwr", wq_addr.size() - base, 3);
        for (int i = 0; i < 3; i++) begin
            chk("p3_addr", wq_addr[base+i], i);
            chk("p3_data", wq_data[base+i], prog[i]);
        end
        chk("p3_cyc1", wq_cyc[base+1] - wq_cyc[base], 1);
        chk("p3_cyc2", wq_cyc[base+2] - wq_cyc[base+1], 1);
        chk("run_idle_we", imem_we, 0);

        // Gapped valid, four words
        do_restart();
        chk("rs_done_lo", done, 0);
        chk("rs_rstn_lo", core_rstn, 0);
        wait_ready("gap_ready");
        base = wq_addr.size();
        csum_tb = '0;
        for (int i = 0; i < 4; i++) begin
            send(32'h00a00013 + 32'(i), i == 3);
            if (i < 3) begin
                @(posedge clk); #1;
            end
        end
        end_prog();
        wait_done("gap_done");
        chk("gap_nwr", wq_addr.size() - base, 4);
        for (int i = 0; i < 4; i++)
            chk("gap_addr", wq_addr[base+i], i);
        chk("gap_words", words_loaded, 4);

        // Restart during a valid transfer cycle
        do_restart();
        wait_ready("mid_ready");
        csum_tb = '0;
        send(32'h11111111, 1'b0);
        send(32'h22222222, 1'b0);
        in_valid = 1'b1;
        in_data  = 32'h33333333;
        restart  = 1'b1;
        @(posedge clk); #1;
        restart  = 1'b0;
        in_valid = 1'b0;
        base = wq_addr.size();
        chk("mid_words0", words_loaded, 0);
        chk("mid_ready_lo", in_ready, 0);
        chk("mid_rstn_lo", core_rstn, 0);
        wait_ready("mid_reload");
        chk("mid_no_write", wq_addr.size() - base, 0);
        csum_tb = '0;
        send(32'h00000013, 1'b1);
        end_prog();
        wait_done("one_done");
        chk("one_clr_run", last_run, 32);
        chk("one_words", words_loaded, 1);
        chk("one_overflow", overflow, 0);
        chk("one_nwr", wq_addr.size() - base, 1);
        chk("one_addr", wq_addr[base], 0);

        // Overflow on the depth-4 instance
        bw[0] = 32'h00000013;
        bw[1] = 32'h00100093;
        bw[2] = 32'h00200113;
        bw[3] = 32'h00300193;
        bw[5] = 32'h00400213;
`ifdef BOOT_CHECKSUM_EN
        bw[4] = bw[0] ^ bw[1] ^ bw[2] ^ bw[3];
        b_exp_acc = 5;
`else
        bw[4] = 32'h00500293;
        b_exp_acc = 4;
`endif
        chk("ovf_ready0", b_ready, 1);
        b_acc = 0;
        b_valid = 1'b1;
        for (int k = 0; k < 6; k++) begin
            b_data = bw[k];
            if (b_ready === 1'b1)
                b_acc++;
            @(posedge clk); #1;
        end
        b_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("ovf_acc", b_acc, b_exp_acc);
        chk("ovf_words", b_words, 4);
        chk("ovf_flag", b_overflow, 1);
        chk("ovf_nwr", b_wcnt, 4);
        chk("ovf_addr", b_bad, 0);
        chk("ovf_rstn", b_core_rstn, 1);
        chk("ovf_done", b_done, 1);
        chk("ovf_err", b_err, 0);

`ifdef BOOT_CHECKSUM_EN
        do_restart();
        wait_ready("ck_ready");
        send(32'h11, 1'b0);
        send(32'h22, 1'b1);
        send(32'h33, 1'b0);
        wait_done("ck_done");
        chk("ck_err0", err, 0);
        do_restart();
        wait_ready("ck_ready2");
        send(32'h11, 1'b0);
        send(32'h22, 1'b1);
        send(32'h34, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        chk("ck_err1", err, 1);
        chk("ck_rstn", core_rstn, 0);
        chk("ck_done0", done, 0);
        do_restart();
        chk("ck_err_clr", err, 0);
`else
        chk("err_tied", err, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
